// File: rtl/sl_fifo_arb_pkg.sv
// Shared types for the round-robin write arbiter of the async FIFO.
package sl_fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    function automatic int id_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sl_rr_pick.sv
// Cyclic priority search: first set request after last_id, wrapping.
module sl_rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    last_id,
    output logic               valid,
    output logic [ID_W-1:0]    pick_id
);

    int pos;

    // Scan farthest-first so the nearest hit after last_id wins.
    always_comb begin
        valid   = 1'b0;
        pick_id = '0;
        pos     = 0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            pos = int'(last_id) + k;
            if (pos >= NUM_REQ) begin
                pos = pos - NUM_REQ;
            end
            if (req[pos[ID_W-1:0]]) begin
                valid   = 1'b1;
                pick_id = pos[ID_W-1:0];
            end
        end
    end

endmodule

// File: rtl/sl_fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one async FIFO write port.
module sl_fifo_wr_arbiter
    import sl_fifo_arb_pkg::*;
#(
    parameter int  NUM_REQ   = 4,
    parameter int  DATA_SIZE = 8,
    parameter int  MAX_BURST = 4,
    localparam int ID_W      = id_width(NUM_REQ)
) (
    input  logic                      wr_clk,
    input  logic                      rd_rst_n,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_SIZE-1:0] req_data,
    output logic [NUM_REQ-1:0]        ack,
    output logic [ID_W+DATA_SIZE-1:0] fifo_wr_data,
    output logic                      fifo_wr_inc,
    input  logic                      fifo_wr_full,
    output logic [ID_W-1:0]           grant_id,
    output logic                      busy
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);
    localparam logic [ID_W-1:0]  RST_LAST  = ID_W'(NUM_REQ - 1);

    arb_state_t       r_state;
    logic [ID_W-1:0]  r_grant_id;
    logic [ID_W-1:0]  r_last_id;
    logic [CNT_W-1:0] r_beat_cnt;

    logic                 w_pick_valid;
    logic [ID_W-1:0]      w_pick_id;
    logic                 w_req_g;
    logic                 w_xfer;
    logic [DATA_SIZE-1:0] w_words [NUM_REQ];

    sl_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_pick (
        .req     (req),
        .last_id (r_last_id),
        .valid   (w_pick_valid),
        .pick_id (w_pick_id)
    );

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            w_words[i] = req_data[i*DATA_SIZE +: DATA_SIZE];
        end
    end

    assign busy    = (r_state == GRANT);
    assign w_req_g = req[r_grant_id];
    assign w_xfer  = busy & w_req_g & ~fifo_wr_full;

    assign grant_id     = r_grant_id;
    assign fifo_wr_inc  = w_xfer;
    assign ack          = w_xfer ? (NUM_REQ'(1) << r_grant_id) : '0;
    assign fifo_wr_data = {r_grant_id, w_words[r_grant_id]};

    // A full FIFO simply freezes the burst; only a dropped request ends it early.
    always_ff @(posedge wr_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            r_state    <= IDLE;
            r_grant_id <= '0;
            r_last_id  <= RST_LAST;
            r_beat_cnt <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_pick_valid) begin
                        r_grant_id <= w_pick_id;
                        r_beat_cnt <= '0;
                        r_state    <= GRANT;
                    end
                end
                GRANT: begin
                    if (w_xfer) begin
                        r_beat_cnt <= r_beat_cnt + CNT_W'(1);
                    end
                    if (!w_req_g || (w_xfer && r_beat_cnt == LAST_BEAT)) begin
                        r_state   <= IDLE;
                        r_last_id <= r_grant_id;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sl_fifo_wr_arbiter.sv
// Bench for sl_fifo_wr_arbiter: queue-style model checked every cycle.
module tb_sl_fifo_wr_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int MB = 4;
    localparam int IW = 2;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    req = '0;
    logic [N*DW-1:0] req_data = '0;
    logic [N-1:0]    ack;
    logic [IW+DW-1:0] wdata;
    logic            winc;
    logic            full = 1'b0;
    logic [IW-1:0]   gid;
    logic            busy;

    sl_fifo_wr_arbiter #(
        .NUM_REQ   (N),
        .DATA_SIZE (DW),
        .MAX_BURST (MB)
    ) dut (
        .wr_clk       (clk),
        .rd_rst_n     (rst_n),
        .req          (req),
        .req_data     (req_data),
        .ack          (ack),
        .fifo_wr_data (wdata),
        .fifo_wr_inc  (winc),
        .fifo_wr_full (full),
        .grant_id     (gid),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Requester side: rem words left to send, seq = tag of current word
    int rem [N];
    int seq [N];
    logic [N-1:0] s_ack = '0;

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req[i] = (rem[i] > 0);
            req_data[i*DW +: DW] = {2'(i), 6'(seq[i])};
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (s_ack[i] && rem[i] > 0) begin
                rem[i]--;
                seq[i]++;
            end
        end
        drive();
    endtask

    // Model: who holds the port, how many words it moved, who went last
    int m_busy = 0;
    int m_gid = 0;
    int m_last = N - 1;
    int m_beats = 0;
    int wr_cnt [N];
    int exp_seq [N];
    int win_cnt = 0;
    int grant_log [$];

    logic         x;
    logic [N-1:0] eack;
    int           cand;

    always @(negedge clk) begin
        s_ack = ack;
        if (!rst_n) begin
            chk("rst_ack", 32'(ack), 0);
            chk("rst_inc", 32'(winc), 0);
            chk("rst_busy", 32'(busy), 0);
            chk("rst_gid", 32'(gid), 0);
            m_busy  = 0;
            m_gid   = 0;
            m_last  = N - 1;
            m_beats = 0;
        end else begin
            x = (m_busy != 0) && req[m_gid[1:0]] && !full;
            eack = x ? (N'(1) << m_gid) : '0;
            chk("ack", 32'(ack), 32'(eack));
            chk("inc", 32'(winc), 32'(x));
            chk("busy", 32'(busy), 32'(m_busy));
            chk("gid", 32'(gid), 32'(m_gid));
            if (x) begin
                chk("data", 32'(wdata),
                    32'({2'(m_gid), req_data[m_gid*DW +: DW]}));
                chk("order", 32'(wdata[5:0]), 32'(6'(exp_seq[m_gid])));
                exp_seq[m_gid]++;
                wr_cnt[m_gid]++;
                win_cnt++;
            end
            if (m_busy == 0) begin
                if (req != '0) begin
                    for (int off = 1; off <= N; off++) begin
                        cand = (m_last + off) % N;
                        if (req[cand[1:0]]) begin
                            m_gid = cand;
                            break;
                        end
                    end
                    m_busy  = 1;
                    m_beats = 0;
                    grant_log.push_back(m_gid);
                end
            end else if (!req[m_gid[1:0]] || (x && m_beats + 1 == MB)) begin
                m_busy = 0;
                m_last = m_gid;
            end else if (x) begin
                m_beats++;
            end
        end
    end

    task automatic clear_counts();
        for (int i = 0; i < N; i++) wr_cnt[i] = 0;
        win_cnt = 0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        full  = 1'b0;
        for (int i = 0; i < N; i++) rem[i] = 0;
        drive();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        clear_counts();
    endtask

    task automatic wait_drain(input int budget);
        int n;
        int pend;
        n = 0;
        pend = 1;
        while (pend != 0 && n < budget) begin
            cyc();
            n++;
            pend = busy ? 1 : 0;
            for (int i = 0; i < N; i++) if (rem[i] > 0) pend = 1;
        end
        chk("drain_in_time", 32'(n < budget), 1);
    endtask

    task automatic wait_cnt(input int id, input int cnt, input int budget);
        int n;
        n = 0;
        while (wr_cnt[id] < cnt && n < budget) begin
            cyc();
            n++;
        end
        chk("count_in_time", 32'(n < budget), 1);
    endtask

    int fair [5] = '{0, 1, 2, 3, 0};
    int gl0;

    initial begin
        for (int i = 0; i < N; i++) begin
            rem[i] = 0;
            seq[i] = 0;
            exp_seq[i] = 0;
            wr_cnt[i] = 0;
        end
        drive();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        chk("reset_busy", 32'(busy), 0);
        chk("reset_gid", 32'(gid), 0);
        chk("reset_ack", 32'(ack), 0);
        chk("reset_inc", 32'(winc), 0);

        // single requester, full burst then one idle cycle
        clear_counts();
        rem[0] = 4;
        drive();
        gl0 = grant_log.size();
        cyc();
        #1;
        chk("t1_busy", 32'(busy), 1);
        chk("t1_gid", 32'(gid), 0);
        chk("t1_ack", 32'(ack), 32'h1);
        chk("t1_data", 32'(wdata), 32'h000);
        repeat (4) cyc();
        #1;
        chk("t1_idle", 32'(busy), 0);
        chk("t1_writes", 32'(win_cnt), 4);
        chk("t1_grant", 32'(grant_log[gl0]), 0);

        // fairness with everyone requesting
        do_reset();
        for (int i = 0; i < N; i++) rem[i] = 8;
        drive();
        gl0 = grant_log.size();
        win_cnt = 0;
        repeat (20) cyc();
        chk("t2_16_in_20", 32'(win_cnt), 16);
        wait_drain(200);
        chk("t2_bursts", 32'(grant_log.size() - gl0), 8);
        for (int k = 0; k < 5; k++) begin
            chk("t2_order", 32'(grant_log[gl0 + k]), 32'(fair[k]));
        end
        for (int i = 0; i < N; i++) chk("t2_words", 32'(wr_cnt[i]), 8);

        // early drop by requester 2, then 0 wins over 2
        do_reset();
        rem[2] = 2;
        drive();
        wait_drain(50);
        chk("t3_w2", 32'(wr_cnt[2]), 2);
        chk("t3_idle", 32'(busy), 0);
        rem[0] = 1;
        rem[2] = 1;
        drive();
        cyc();
        #1;
        chk("t3_pick", 32'(gid), 0);
        chk("t3_busy", 32'(busy), 1);
        wait_drain(50);
        chk("t3_w0", 32'(wr_cnt[0]), 1);
        chk("t3_w2b", 32'(wr_cnt[2]), 3);

        // five-cycle full stall mid-burst
        do_reset();
        rem[1] = 4;
        drive();
        wait_cnt(1, 2, 50);
        full = 1'b1;
        win_cnt = 0;
        repeat (5) cyc();
        chk("t4_stall", 32'(win_cnt), 0);
        chk("t4_busy", 32'(busy), 1);
        chk("t4_gid", 32'(gid), 1);
        full = 1'b0;
        wait_drain(50);
        chk("t4_words", 32'(wr_cnt[1]), 4);

        // full exactly on the fourth beat
        do_reset();
        rem[3] = 4;
        drive();
        wait_cnt(3, 3, 50);
        full = 1'b1;
        win_cnt = 0;
        cyc();
        chk("t5_nowrite", 32'(win_cnt), 0);
        chk("t5_held", 32'(busy), 1);
        full = 1'b0;
        cyc();
        chk("t5_last", 32'(win_cnt), 1);
        chk("t5_idle", 32'(busy), 0);
        chk("t5_words", 32'(wr_cnt[3]), 4);

        // asynchronous reset during beat 2
        do_reset();
        rem[0] = 4;
        drive();
        wait_cnt(0, 1, 50);
        #1;
        chk("t6_pre_ack", 32'(ack), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("t6_ack", 32'(ack), 0);
        chk("t6_inc", 32'(winc), 0);
        chk("t6_busy", 32'(busy), 0);
        for (int i = 0; i < N; i++) rem[i] = 0;
        drive();
        repeat (2) cyc();
        rst_n = 1'b1;
        clear_counts();
        for (int i = 0; i < N; i++) rem[i] = 1;
        drive();
        cyc();
        #1;
        chk("t6_gid", 32'(gid), 0);
        chk("t6_busy1", 32'(busy), 1);
        wait_drain(100);
        for (int i = 0; i < N; i++) chk("t6_words", 32'(wr_cnt[i]), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
